// File: rtl/irq_pending_dispatch.sv
// ----------------------------------------------------------------------------
// irq_pending_dispatch
//
// Collects 2**SIZE interrupt request lines into a pending register using
// rising-edge capture. The masked pending vector goes out to an external
// priority encoder. The encoder's index/valid comes back in, and the block
// offers one grant at a time on a valid/ready handshake. The granted pending
// bit is cleared when the consumer accepts.
//
// Ports
//   clk_i          in   1       clock, all state on rising edge
//   rst_i          in   1       asynchronous active-high reset
//   req_i          in   N       raw request lines, rising edge = new event
//   mask_i         in   N       1 = line masked (stays pending, not offered)
//   enc_in_o       out  N       pending & ~mask_i, to the encoder input
//   enc_idx_i      in   SIZE    encoder index (ignored while enc_valid_i=0)
//   enc_valid_i    in   1       encoder valid
//   grant_valid_o  out  1       grant offered
//   grant_idx_o    out  SIZE    index of the offered line
//   grant_ready_i  in   1       consumer accepts the grant
//   pend_cnt_o     out  SIZE+1  popcount of the pending register
//   ovf_o          out  1       sticky: event lost on an already-pending line
//   ovf_clr_i      in   1       clears ovf_o (a new overflow wins)
// ----------------------------------------------------------------------------
module irq_pending_dispatch #(
    parameter int SIZE = 5,
    localparam int N = 2 ** SIZE
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    req_i,
    input  logic [N-1:0]    mask_i,
    output logic [N-1:0]    enc_in_o,
    input  logic [SIZE-1:0] enc_idx_i,
    input  logic            enc_valid_i,
    output logic            grant_valid_o,
    output logic [SIZE-1:0] grant_idx_o,
    input  logic            grant_ready_i,
    output logic [SIZE:0]   pend_cnt_o,
    output logic            ovf_o,
    input  logic            ovf_clr_i
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    req_q;
    logic [N-1:0]    pend_q, pend_d;
    logic [SIZE-1:0] idx_q, idx_d;
    logic [SIZE:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;

    logic [N-1:0]    rise;
    logic [N-1:0]    clr;

    function automatic logic [SIZE:0] popcount(input logic [N-1:0] v);
        logic [SIZE:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + {{SIZE{1'b0}}, v[i]};
        end
        return c;
    endfunction

    assign grant_valid_o = (state_q == OFFER);
    assign grant_idx_o   = idx_q;
    assign pend_cnt_o    = cnt_q;
    assign ovf_o         = ovf_q;
    assign enc_in_o      = pend_q & ~mask_i;

    assign rise = req_i & ~req_q;

    // Pending / overflow next state. A rise on the bit being cleared in the
    // same cycle re-arms it and is not counted as an overflow.
    always_comb begin
        clr = '0;
        if (grant_valid_o && grant_ready_i) begin
            clr[idx_q] = 1'b1;
        end
        pend_d = rise | (pend_q & ~clr);
        cnt_d  = popcount(pend_d);
        if (|(rise & pend_q & ~clr)) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Grant FSM. Returning to IDLE after every accept gives the encoder one
    // cycle to see the cleared bit before the next index is captured.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (enc_valid_i) begin
                    idx_d   = enc_idx_i;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (grant_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            req_q   <= '0;
            pend_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_i;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_irq_pending_dispatch.sv
// ----------------------------------------------------------------------------
// tb_irq_pending_dispatch
//
// Bench for irq_pending_dispatch. Plays the role of the priority encoder
// (highest set bit wins) and compares the DUT cycle by cycle against a
// behavioural model of pending lines, overflow flag and the current offer.
// Directed scenarios are followed by a randomized run and an asynchronous
// reset in the middle of an offer.
// ----------------------------------------------------------------------------
module tb_irq_pending_dispatch;

    localparam int SIZE = 5;
    localparam int N    = 2 ** SIZE;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    mask;
    logic [N-1:0]    enc_in;
    logic [SIZE-1:0] enc_idx;
    logic            enc_valid;
    logic            gnt_valid;
    logic [SIZE-1:0] gnt_idx;
    logic            gnt_ready;
    logic [SIZE:0]   pend_cnt;
    logic            ovf;
    logic            ovf_clr;
    logic [SIZE-1:0] junk_idx;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit m_req_prev [N];
    bit m_pend     [N];
    bit m_ovf;
    bit m_offer;
    int m_idx;
    int m_cnt;

    irq_pending_dispatch #(.SIZE(SIZE)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .mask_i        (mask),
        .enc_in_o      (enc_in),
        .enc_idx_i     (enc_idx),
        .enc_valid_i   (enc_valid),
        .grant_valid_o (gnt_valid),
        .grant_idx_o   (gnt_idx),
        .grant_ready_i (gnt_ready),
        .pend_cnt_o    (pend_cnt),
        .ovf_o         (ovf),
        .ovf_clr_i     (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Priority encoder stand-in: highest set bit wins; index is junk when
    // nothing is set so the DUT must honour enc_valid.
    always_comb begin
        enc_valid = 1'b0;
        enc_idx   = junk_idx;
        for (int b = 0; b < N; b++) begin
            if (enc_in[b]) begin
                enc_valid = 1'b1;
                enc_idx   = SIZE'(b);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < N; b++) begin
            m_req_prev[b] = 1'b0;
            m_pend[b]     = 1'b0;
        end
        m_ovf   = 1'b0;
        m_offer = 1'b0;
        m_idx   = 0;
        m_cnt   = 0;
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_enc;
        exp_enc = '0;
        for (int b = 0; b < N; b++) exp_enc[b] = m_pend[b] & ~mask[b];
        chk("grant_valid", 64'(gnt_valid), 64'(m_offer));
        chk("grant_idx",   64'(gnt_idx),   64'(m_idx));
        chk("pend_cnt",    64'(pend_cnt),  64'(m_cnt));
        chk("ovf",         64'(ovf),       64'(m_ovf));
        chk("enc_in",      64'(enc_in),    64'(exp_enc));
    endtask

    // One clock: model next state from current inputs, clock, compare.
    task automatic step();
        bit n_pend [N];
        bit n_ovf, n_offer, ovf_hit;
        int n_idx, n_cnt, top;
        ovf_hit = 1'b0;
        n_cnt   = 0;
        for (int b = 0; b < N; b++) begin
            bit r, c;
            r = req[b] && !m_req_prev[b];
            c = m_offer && gnt_ready && (m_idx == b);
            if (r && m_pend[b] && !c) ovf_hit = 1'b1;
            n_pend[b] = r || (m_pend[b] && !c);
            n_cnt += int'(n_pend[b]);
        end
        n_ovf = ovf_hit ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
        n_offer = m_offer;
        n_idx   = m_idx;
        if (m_offer) begin
            if (gnt_ready) n_offer = 1'b0;
        end else begin
            top = -1;
            for (int b = 0; b < N; b++) if (m_pend[b] && !mask[b]) top = b;
            if (top >= 0) begin
                n_offer = 1'b1;
                n_idx   = top;
            end
        end
        @(posedge clk);
        #1;
        for (int b = 0; b < N; b++) begin
            m_req_prev[b] = req[b];
            m_pend[b]     = n_pend[b];
        end
        m_ovf   = n_ovf;
        m_offer = n_offer;
        m_idx   = n_idx;
        m_cnt   = n_cnt;
        junk_idx = SIZE'($urandom);
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int got_q[$];

    initial begin
        rst       = 1'b1;
        req       = '0;
        mask      = '0;
        gnt_ready = 1'b0;
        ovf_clr   = 1'b0;
        junk_idx  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 64'(gnt_valid), 64'd0);
        chk("reset_cnt",   64'(pend_cnt),  64'd0);
        chk("reset_enc",   64'(enc_in),    64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single event on line 3
        req = 32'h8;
        step();
        req = '0;
        chk("single_enc", 64'(enc_in), 64'h8);
        chk("single_nov", 64'(gnt_valid), 64'd0);
        step();
        chk("single_vld", 64'(gnt_valid), 64'd1);
        chk("single_idx", 64'(gnt_idx), 64'd3);
        gnt_ready = 1'b1;
        step();
        gnt_ready = 1'b0;
        chk("single_cnt0", 64'(pend_cnt), 64'd0);
        run(2);

        // Priority with ready tied high
        req = (32'd1 << 2) | (32'd1 << 17) | (32'd1 << 31);
        gnt_ready = 1'b1;
        step();
        req = '0;
        chk("prio_cnt3", 64'(pend_cnt), 64'd3);
        for (int i = 0; i < 8; i++) begin
            step();
            if (gnt_valid) got_q.push_back(int'(gnt_idx));
        end
        chk("prio_n",  64'(got_q.size()), 64'd3);
        if (got_q.size() == 3) begin
            chk("prio_0", 64'(got_q[0]), 64'd31);
            chk("prio_1", 64'(got_q[1]), 64'd17);
            chk("prio_2", 64'(got_q[2]), 64'd2);
        end
        gnt_ready = 1'b0;

        // Mask behaviour
        mask = 32'd1 << 9;
        req  = (32'd1 << 5) | (32'd1 << 9);
        step();
        req = '0;
        run(2);
        chk("mask_idx5", 64'(gnt_idx), 64'd5);
        gnt_ready = 1'b1;
        step();
        gnt_ready = 1'b0;
        mask = '0;
        run(2);
        chk("unmask_idx9", 64'(gnt_idx), 64'd9);
        chk("unmask_vld",  64'(gnt_valid), 64'd1);
        gnt_ready = 1'b1;
        step();
        gnt_ready = 1'b0;
        req = 32'd1 << 5;
        step();
        req = '0;
        run(2);
        mask = 32'd1 << 5;
        run(3);
        chk("masked_hold_vld", 64'(gnt_valid), 64'd1);
        chk("masked_hold_idx", 64'(gnt_idx), 64'd5);
        gnt_ready = 1'b1;
        step();
        gnt_ready = 1'b0;
        mask = '0;
        run(2);

        // Overflow on line 7
        req = 32'd1 << 7;
        step();
        req = '0;
        run(2);
        req = 32'd1 << 7;
        step();
        chk("ovf_set", 64'(ovf), 64'd1);
        chk("ovf_cnt", 64'(pend_cnt), 64'd1);
        req = '0;
        step();
        req = 32'd1 << 7;
        ovf_clr = 1'b1;
        step();
        chk("ovf_setwins", 64'(ovf), 64'd1);
        req = '0;
        step();
        ovf_clr = 1'b0;
        chk("ovf_cleared", 64'(ovf), 64'd0);
        gnt_ready = 1'b1;
        step();
        gnt_ready = 1'b0;
        run(2);

        // Same-cycle set and clear on line 12
        req = 32'd1 << 12;
        step();
        req = '0;
        run(2);
        req = 32'd1 << 12;
        gnt_ready = 1'b1;
        step();
        gnt_ready = 1'b0;
        req = '0;
        chk("sameclr_cnt", 64'(pend_cnt), 64'd1);
        chk("sameclr_ovf", 64'(ovf), 64'd0);
        step();
        chk("sameclr_reoffer", 64'(gnt_valid), 64'd1);
        chk("sameclr_idx",     64'(gnt_idx),   64'd12);
        gnt_ready = 1'b1;
        step();
        gnt_ready = 1'b0;
        run(2);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            req       = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 3) == 0) mask = $urandom & $urandom;
            gnt_ready = 1'($urandom_range(0, 1));
            ovf_clr   = ($urandom_range(0, 7) == 0);
            step();
        end
        req       = '0;
        mask      = '0;
        gnt_ready = 1'b0;
        ovf_clr   = 1'b0;
        run(3);

        // Asynchronous reset in the middle of an offer
        req = (32'd1 << 20) | (32'd1 << 4);
        step();
        req = '0;
        step();
        req = 32'd1 << 20;
        step();
        req = '0;
        chk("pre_rst_vld", 64'(gnt_valid), 64'd1);
        chk("pre_rst_ovf", 64'(ovf), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_vld", 64'(gnt_valid), 64'd0);
        chk("async_rst_ovf", 64'(ovf), 64'd0);
        chk("async_rst_cnt", 64'(pend_cnt), 64'd0);
        chk("async_rst_idx", 64'(gnt_idx), 64'd0);
        chk("async_rst_enc", 64'(enc_in), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
